axis_red_pitaya_dac_4ch: RTL and testbench

Four-channel DAC transmitter: accepts packed 4×16-bit signed samples on an AXI4-Stream slave, saturates each to 14 bits, converts to the DAC's inverted-magnitude code, and presents per-channel 7-bit rising/falling-edge halves for external ODDR primitives (7 pins/channel). It is the transmit-side counterpart of the 4-channel ADC capture path, uses the same 64-bit sample packing and the same bit coding, and runs entirely in the DAC sample clock domain.

---
 rtl/axis_red_pitaya_dac_4ch.sv | 254 +++++++++++++++++++++++++
 tb/tb_axis_red_pitaya_dac_4ch.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_red_pitaya_dac_4ch.sv
// Four-channel DAC transmitter for Red Pitaya style DDR DAC pins.
// Takes packed 4x16-bit signed samples from an AXI4-Stream slave,
// clamps each to 14 bits and converts them to the DAC's inverted-magnitude
// code. Each 14-bit code is then split into 7-bit rising/falling-edge
// halves for external ODDR primitives. Everything runs in the DAC sample
// clock domain.
module axis_red_pitaya_dac_4ch #(
  // 1: an underrun repeats the last sample, 0: an underrun emits midscale
  parameter logic IDLE_HOLD = 1'b1
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        enable,
  input  logic        clear_stat,
  output logic [27:0] dac_dat_rise,
  output logic [27:0] dac_dat_fall,
  output logic [15:0] underrun_cnt,
  output logic [3:0]  sat_flag
);

  // Pin pattern for the midscale code 0x1FFF on every channel
  localparam logic [27:0] MID_RISE = 28'hFFFFFFF;
  localparam logic [27:0] MID_FALL = 28'h7EFDFBF;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  // ---------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------

  // Clamp a signed 16-bit value into the signed 14-bit range
  function automatic logic [13:0] sat14(input logic [15:0] v);
    logic [13:0] r;
    if ((v[15] == 1'b0) && (v[14:13] != 2'b00)) begin
      r = 14'h1FFF;
    end else if ((v[15] == 1'b1) && (v[14:13] != 2'b11)) begin
      r = 14'h2000;
    end else begin
      r = v[13:0];
    end
    return r;
  endfunction

  // True when the value lies outside the signed 14-bit range
  function automatic logic is_sat(input logic [15:0] v);
    return (v[15:13] != 3'b000) && (v[15:13] != 3'b111);
  endfunction

  // Inverted-magnitude DAC code: +max -> 0x0000, 0 -> 0x1FFF, -max -> 0x3FFF
  function automatic logic [13:0] dac_code(input logic [13:0] s);
    return {s[13], ~s[12:0]};
  endfunction

  // Even-numbered code bits, driven on the rising edge
  function automatic logic [6:0] even_bits(input logic [13:0] c);
    logic [6:0] r;
    r = 7'd0;
    for (int k = 0; k < 7; k++) begin
      r[k] = c[2*k];
    end
    return r;
  endfunction

  // Odd-numbered code bits, driven on the falling edge
  function automatic logic [6:0] odd_bits(input logic [13:0] c);
    logic [6:0] r;
    r = 7'd0;
    for (int k = 0; k < 7; k++) begin
      r[k] = c[2*k+1];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Two-entry input FIFO
  // ---------------------------------------------------------------------
  logic [63:0] fifo_mem_q [0:1];
  logic        wr_ptr_q;
  logic        wr_ptr_d;
  logic        rd_ptr_q;
  logic        rd_ptr_d;
  logic [1:0]  count_q;
  logic [1:0]  count_d;

  logic        fifo_full_s;
  logic        push_s;
  logic        pop_s;
  logic        underrun_s;
  logic [63:0] head_s;

  // Handshake, pop/underrun decode and FIFO bookkeeping
  always_comb begin
    fifo_full_s   = (count_q == 2'd2);
    // Depends only on registered state, never on tvalid
    s_axis_tready = ~areset & ~fifo_full_s;
    push_s        = s_axis_tvalid & s_axis_tready;
    pop_s         = enable & (count_q != 2'd0);
    underrun_s    = enable & (count_q == 2'd0);
    head_s        = fifo_mem_q[rd_ptr_q];

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers and fill count
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_mem_q[i] <= 64'd0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_q[wr_ptr_q] <= s_axis_tdata;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1: per-channel saturation / idle selection
  // ---------------------------------------------------------------------
  logic [13:0] s1_q [0:3];
  logic [13:0] s1_d [0:3];
  logic [3:0]  sat_evt_s;

  // Choose the next stage-1 value: popped sample, held/zero on underrun, or zero when disabled
  always_comb begin
    sat_evt_s = 4'd0;
    for (int c = 0; c < 4; c++) begin
      s1_d[c] = 14'd0;
      if (pop_s) begin
        s1_d[c]      = sat14(head_s[16*c +: 16]);
        sat_evt_s[c] = is_sat(head_s[16*c +: 16]);
      end else if (underrun_s) begin
        if (IDLE_HOLD) begin
          s1_d[c] = s1_q[c];
        end else begin
          s1_d[c] = 14'd0;
        end
      end else begin
        s1_d[c] = 14'd0;
      end
    end
  end

  // Stage-1 sample registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int c = 0; c < 4; c++) begin
        s1_q[c] <= 14'd0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        s1_q[c] <= s1_d[c];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Status: underrun counter and sticky saturation flags
  // ---------------------------------------------------------------------
  logic [15:0] underrun_cnt_q;
  logic [15:0] underrun_cnt_d;
  logic [3:0]  sat_flag_q;
  logic [3:0]  sat_flag_d;

  // clear_stat wins over any same-cycle underrun or saturation event
  always_comb begin
    underrun_cnt_d = underrun_cnt_q;
    sat_flag_d     = sat_flag_q;
    if (clear_stat) begin
      underrun_cnt_d = 16'd0;
      sat_flag_d     = 4'd0;
    end else begin
      if (underrun_s && (underrun_cnt_q != CNT_MAX)) begin
        underrun_cnt_d = underrun_cnt_q + 16'd1;
      end else begin
        underrun_cnt_d = underrun_cnt_q;
      end
      sat_flag_d = sat_flag_q | sat_evt_s;
    end
  end

  // Status registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      underrun_cnt_q <= 16'd0;
      sat_flag_q     <= 4'd0;
    end else begin
      underrun_cnt_q <= underrun_cnt_d;
      sat_flag_q     <= sat_flag_d;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: code conversion and DDR split
  // ---------------------------------------------------------------------
  logic [13:0] code_s [0:3];
  logic [27:0] rise_q;
  logic [27:0] rise_d;
  logic [27:0] fall_q;
  logic [27:0] fall_d;

  // Convert each stage-1 value to its DAC code and split it into edge halves
  always_comb begin
    rise_d = 28'd0;
    fall_d = 28'd0;
    for (int c = 0; c < 4; c++) begin
      code_s[c]          = dac_code(s1_q[c]);
      rise_d[7*c +: 7]   = even_bits(code_s[c]);
      fall_d[7*c +: 7]   = odd_bits(code_s[c]);
    end
  end

  // Output pin registers; reset drives midscale on all channels
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rise_q <= MID_RISE;
      fall_q <= MID_FALL;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dac_dat_rise = rise_q;
  assign dac_dat_fall = fall_q;
  assign underrun_cnt = underrun_cnt_q;
  assign sat_flag     = sat_flag_q;

endmodule

// File: tb/tb_axis_red_pitaya_dac_4ch.sv
// Self-checking bench for axis_red_pitaya_dac_4ch. Two instances (hold and
// midscale idle behaviour) share one stimulus stream. A queue/arithmetic
// reference model pushes the expected pin state after every clock edge
// and an independent monitor pops and compares on the falling edge.
module tb_axis_red_pitaya_dac_4ch;

  logic        aclk       = 1'b0;
  logic        areset     = 1'b1;
  logic [63:0] tdata      = 64'd0;
  logic        tvalid     = 1'b0;
  logic        enable     = 1'b0;
  logic        clear_stat = 1'b0;

  logic        tready_h, tready_z;
  logic [27:0] rise_h, fall_h, rise_z, fall_z;
  logic [15:0] ur_h, ur_z;
  logic [3:0]  sat_h, sat_z;

  always #5 aclk = ~aclk;

  axis_red_pitaya_dac_4ch #(.IDLE_HOLD(1'b1)) dut_hold (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_h),
    .enable(enable), .clear_stat(clear_stat),
    .dac_dat_rise(rise_h), .dac_dat_fall(fall_h),
    .underrun_cnt(ur_h), .sat_flag(sat_h)
  );

  axis_red_pitaya_dac_4ch #(.IDLE_HOLD(1'b0)) dut_zero (
    .aclk(aclk), .areset(areset),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready_z),
    .enable(enable), .clear_stat(clear_stat),
    .dac_dat_rise(rise_z), .dac_dat_fall(fall_z),
    .underrun_cnt(ur_z), .sat_flag(sat_z)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
    end
  endtask

  // ---------------- reference model helpers ----------------
  function automatic int sval(input logic [15:0] x);
    return int'($signed(x));
  endfunction

  function automatic int clampv(input logic [15:0] x);
    int v;
    v = sval(x);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic bit satd(input logic [15:0] x);
    int v;
    v = sval(x);
    return (v > 8191) || (v < -8192);
  endfunction

  // The DAC code of a 14-bit value v is simply 8191 - v
  function automatic logic [27:0] half(input int s0, input int s1, input int s2,
                                       input int s3, input int odd);
    int sv [4];
    int code;
    logic [27:0] r;
    r = 28'd0;
    sv[0] = s0; sv[1] = s1; sv[2] = s2; sv[3] = s3;
    for (int c = 0; c < 4; c++) begin
      code = 8191 - sv[c];
      for (int k = 0; k < 7; k++) begin
        r[7*c+k] = ((code >> (2*k + odd)) & 1) != 0;
      end
    end
    return r;
  endfunction

  // Reassemble the 14-bit code of channel c from the pin halves
  function automatic int dcode(input logic [27:0] r, input logic [27:0] f, input int c);
    int v;
    v = 0;
    for (int k = 0; k < 7; k++) begin
      v = v | (int'(r[7*c+k]) << (2*k)) | (int'(f[7*c+k]) << (2*k+1));
    end
    return v;
  endfunction

  typedef struct {
    logic [27:0] rh, fh, rz, fz;
    logic [15:0] ur;
    logic [3:0]  sat;
    logic        tr;
  } exp_t;

  exp_t        expq [$];
  logic [63:0] mfifo [$];
  int          mh [4];
  int          mz [4];
  int          mur;
  logic [3:0]  msat;

  // Reference model: one step per clock edge, cleared by reset
  initial begin
    exp_t e;
    int nh [4];
    int nz [4];
    bit do_pop, do_push;
    logic [63:0] w;
    mur = 0; msat = 4'd0;
    for (int c = 0; c < 4; c++) begin mh[c] = 0; mz[c] = 0; end
    forever begin
      @(posedge aclk or posedge areset);
      if (areset) begin
        mfifo.delete();
        expq.delete();
        mur = 0; msat = 4'd0;
        for (int c = 0; c < 4; c++) begin mh[c] = 0; mz[c] = 0; end
      end else begin
        e.rh = half(mh[0], mh[1], mh[2], mh[3], 0);
        e.fh = half(mh[0], mh[1], mh[2], mh[3], 1);
        e.rz = half(mz[0], mz[1], mz[2], mz[3], 0);
        e.fz = half(mz[0], mz[1], mz[2], mz[3], 1);
        do_push = tvalid && (mfifo.size() != 2);
        do_pop  = enable && (mfifo.size() > 0);
        if (do_pop) begin
          w = mfifo.pop_front();
          for (int c = 0; c < 4; c++) begin
            nh[c] = clampv(w[16*c +: 16]);
            nz[c] = nh[c];
            if (satd(w[16*c +: 16])) msat[c] = 1'b1;
          end
        end else if (enable) begin
          for (int c = 0; c < 4; c++) begin nh[c] = mh[c]; nz[c] = 0; end
          if (mur < 65535) mur++;
        end else begin
          for (int c = 0; c < 4; c++) begin nh[c] = 0; nz[c] = 0; end
        end
        if (clear_stat) begin mur = 0; msat = 4'd0; end
        if (do_push) mfifo.push_back(tdata);
        for (int c = 0; c < 4; c++) begin mh[c] = nh[c]; mz[c] = nz[c]; end
        e.ur  = mur[15:0];
        e.sat = msat;
        e.tr  = (mfifo.size() != 2);
        expq.push_back(e);
      end
    end
  end

  // Monitor: compare DUT pins against the model on every falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge aclk);
      if (areset) begin
        chk("rst_tready_h", tready_h, 1'b0);
        chk("rst_rise_h", rise_h, 28'hFFFFFFF);
        chk("rst_fall_h", fall_h, 28'h7EFDFBF);
        chk("rst_rise_z", rise_z, 28'hFFFFFFF);
        chk("rst_fall_z", fall_z, 28'h7EFDFBF);
        chk("rst_ur", ur_h, 16'd0);
        chk("rst_sat", sat_h, 4'd0);
      end else if (expq.size() == 0) begin
        chk("post_rst_rise", rise_h, 28'hFFFFFFF);
        chk("post_rst_fall", fall_h, 28'h7EFDFBF);
        chk("post_rst_ur", ur_h, 16'd0);
      end else begin
        e = expq.pop_front();
        chk("sb_rise_h", rise_h, e.rh);
        chk("sb_fall_h", fall_h, e.fh);
        chk("sb_rise_z", rise_z, e.rz);
        chk("sb_fall_z", fall_z, e.fz);
        chk("sb_tready_h", tready_h, e.tr);
        chk("sb_tready_z", tready_z, e.tr);
        chk("sb_ur_h", ur_h, e.ur);
        chk("sb_ur_z", ur_z, e.ur);
        chk("sb_sat_h", sat_h, e.sat);
        chk("sb_sat_z", sat_z, e.sat);
      end
    end
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic chk_codes(input string nm, input bit hold_inst,
                           input int c0, input int c1, input int c2, input int c3);
    logic [27:0] r, f;
    r = hold_inst ? rise_h : rise_z;
    f = hold_inst ? fall_h : fall_z;
    chk({nm, "_ch0"}, dcode(r, f, 0), c0);
    chk({nm, "_ch1"}, dcode(r, f, 1), c1);
    chk({nm, "_ch2"}, dcode(r, f, 2), c2);
    chk({nm, "_ch3"}, dcode(r, f, 3), c3);
  endtask

  // Stimulus
  initial begin
    logic [63:0] samp [$];
    logic [63:0] w;
    int idx, guard;
    bit go;

    // Reset and idle
    repeat (3) tick;
    areset = 1'b0;
    tick;
    chk("idle_tready", tready_h, 1'b1);
    chk("idle_rise", rise_h, 28'hFFFFFFF);
    chk("idle_fall", fall_h, 28'h7EFDFBF);
    chk("idle_ur", ur_h, 16'd0);

    // Coding and latency: ch0=+100 ch1=-1 ch2=0 ch3=+8191
    enable = 1'b1;
    tdata  = {16'h1FFF, 16'h0000, 16'hFFFF, 16'h0064};
    tvalid = 1'b1;
    tick;
    tvalid = 1'b0;
    tick;
    chk_codes("lat_early", 1'b1, 'h1FFF, 'h1FFF, 'h1FFF, 'h1FFF);
    tick;
    chk_codes("code", 1'b1, 'h1F9B, 'h2000, 'h1FFF, 'h0000);
    chk("split_rise_ch0", rise_h[6:0], 7'h75);
    chk("split_fall_ch0", fall_h[6:0], 7'h3B);
    chk("code_sat_none", sat_h, 4'b0000);

    // Saturation: ch0=0x7FFF ch1=0x8000
    tdata  = {16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    tvalid = 1'b1;
    tick;
    tvalid = 1'b0;
    tick;
    tick;
    chk_codes("satcode", 1'b1, 'h0000, 'h3FFF, 'h1FFF, 'h1FFF);
    chk("sat_flag", sat_h, 4'b0011);
    clear_stat = 1'b1;
    tick;
    clear_stat = 1'b0;
    chk("sat_clear", sat_h, 4'b0000);

    // Underrun: three samples then five idle cycles
    enable = 1'b0;
    tvalid = 1'b1;
    tdata  = {16'h0123, 16'hF000, 16'h0456, 16'h0789};
    tick;
    tdata  = {16'h0321, 16'h0F00, 16'hF654, 16'h0987};
    tick;
    tdata  = {16'hF000, 16'h1000, 16'hFC18, 16'h03E8};  // C: 1000, -1000, 4096, -4096
    clear_stat = 1'b1;
    tick;
    clear_stat = 1'b0;
    enable = 1'b1;
    tick;
    tick;
    tvalid = 1'b0;
    tick;
    repeat (5) tick;
    enable = 1'b0;
    chk("urun5_h", ur_h, 16'd5);
    chk("urun5_z", ur_z, 16'd5);
    chk_codes("hold", 1'b1, 'h1C17, 'h23E7, 'h0FFF, 'h2FFF);
    chk_codes("zero", 1'b0, 'h1FFF, 'h1FFF, 'h1FFF, 'h1FFF);

    // Underrun counter saturation
    enable = 1'b1;
    repeat (70000) tick;
    chk("urun_sat_h", ur_h, 16'hFFFF);
    chk("urun_sat_z", ur_z, 16'hFFFF);
    enable = 1'b0;
    clear_stat = 1'b1;
    tick;
    clear_stat = 1'b0;

    // Backpressure then sustained streaming of 1000 random samples
    for (int i = 0; i < 1000; i++) begin
      w = {$urandom, $urandom};
      if ((i % 2) == 1) begin
        for (int c = 0; c < 4; c++) begin
          w[16*c +: 16] = 16'($urandom_range(0, 16383) - 8192);
        end
      end
      samp.push_back(w);
    end
    idx = 0;
    repeat (6) begin
      tvalid = 1'b1;
      tdata  = samp[idx];
      go     = tready_h;
      tick;
      if (go) idx++;
    end
    chk("bp_accepted", idx, 2);
    chk("bp_tready", tready_h, 1'b0);
    enable = 1'b1;
    guard  = 0;
    while ((idx < 1000) && (guard < 3000)) begin
      tvalid = 1'b1;
      tdata  = samp[idx];
      go     = tready_h;
      tick;
      if (go) idx++;
      guard++;
    end
    chk("stream_done", idx, 1000);
    tvalid = 1'b0;
    repeat (4) tick;

    // Random mixed traffic
    repeat (400) begin
      enable     = ($urandom_range(0, 3) != 0);
      tvalid     = ($urandom_range(0, 9) < 7);
      clear_stat = ($urandom_range(0, 31) == 0);
      tdata      = {$urandom, $urandom};
      tick;
    end
    clear_stat = 1'b0;

    // Asynchronous reset mid-stream with a full FIFO
    enable = 1'b0;
    tvalid = 1'b1;
    repeat (3) begin
      tdata = {$urandom, $urandom};
      tick;
    end
    chk("full_tready", tready_h, 1'b0);
    #2;
    areset = 1'b1;
    #1;
    chk("arst_rise", rise_h, 28'hFFFFFFF);
    chk("arst_fall", fall_h, 28'h7EFDFBF);
    chk("arst_tready", tready_h, 1'b0);
    tick;
    tick;
    areset = 1'b0;
    enable = 1'b1;
    tdata  = {16'hE000, 16'hFFFE, 16'h0002, 16'h0001};
    tvalid = 1'b1;
    tick;
    tvalid = 1'b0;
    tick;
    tick;
    chk_codes("post_rst", 1'b1, 'h1FFE, 'h1FFD, 'h2001, 'h3FFF);
    repeat (3) tick;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
